// File: rtl/axil_read_arbiter_if.sv
// ============================================================================
// Module : if_axi_lite
// Brief  : AXI-Lite bus bundle with master (M) and slave (S) modports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface if_axi_lite #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport M (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport S (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/axil_read_arbiter.sv
// ============================================================================
// Module : axil_read_arbiter
// Brief  : Two-port AXI-Lite read arbiter, one outstanding read at a time.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axil_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    if_axi_lite.S      s0,
    if_axi_lite.S      s1,
    if_axi_lite.M      m,
    output logic [1:0] o_grant,
    output logic       o_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [2:0]        arprot_q, arprot_d;

    logic cand_vld;
    logic cand_sel;
    logic rready_sel;
    logic is_idle;
    logic is_data;
    logic sel0;
    logic sel1;

    // Tie goes to the port not served last in round-robin mode, else port 0.
    assign cand_vld = s0.arvalid | s1.arvalid;
    assign cand_sel = (s0.arvalid & s1.arvalid) ? (RR_EN ? ~last_q : 1'b0) : s1.arvalid;

    assign rready_sel = grant_q[1] ? s1.rready : s0.rready;
    assign is_idle    = (state_q == ST_IDLE) & rstn;
    assign is_data    = (state_q == ST_DATA);
    assign sel0       = is_data & grant_q[0];
    assign sel1       = is_data & grant_q[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            araddr_q <= '0;
            arprot_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            araddr_q <= araddr_d;
            arprot_q <= arprot_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        araddr_d = araddr_q;
        arprot_d = arprot_q;
        case (state_q)
            ST_IDLE: begin
                if (cand_vld) begin
                    state_d  = ST_ADDR;
                    grant_d  = cand_sel ? 2'b10 : 2'b01;
                    araddr_d = cand_sel ? s1.araddr : s0.araddr;
                    arprot_d = cand_sel ? s1.arprot : s0.arprot;
                end
            end
            ST_ADDR: begin
                if (m.arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m.rvalid && rready_sel) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_comb begin
        s0.arready = is_idle & cand_vld & ~cand_sel;
        s1.arready = is_idle & cand_vld & cand_sel;

        m.arvalid  = (state_q == ST_ADDR);
        m.araddr   = araddr_q;
        m.arprot   = arprot_q;
        m.rready   = is_data & rready_sel;

        s0.rvalid  = sel0 & m.rvalid;
        s0.rdata   = sel0 ? m.rdata : {DATA_W{1'b0}};
        s0.rresp   = sel0 ? m.rresp : 2'b00;
        s1.rvalid  = sel1 & m.rvalid;
        s1.rdata   = sel1 ? m.rdata : {DATA_W{1'b0}};
        s1.rresp   = sel1 ? m.rresp : 2'b00;

        // Write channels are not arbitrated here and are held quiet.
        m.awaddr   = '0;
        m.awprot   = 3'b000;
        m.awvalid  = 1'b0;
        m.wdata    = '0;
        m.wstrb    = '0;
        m.wvalid   = 1'b0;
        m.bready   = 1'b0;
        s0.awready = 1'b0;
        s0.wready  = 1'b0;
        s0.bvalid  = 1'b0;
        s0.bresp   = 2'b00;
        s1.awready = 1'b0;
        s1.wready  = 1'b0;
        s1.bvalid  = 1'b0;
        s1.bresp   = 2'b00;

        o_grant    = grant_q;
        o_busy     = (state_q != ST_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_axil_read_arbiter.sv
// ============================================================================
// Module : tb_axil_read_arbiter
// Brief  : Directed self-checking bench for round-robin and fixed-priority builds.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axil_read_arbiter;

    logic clk;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    logic [1:0] rr_grant, fp_grant;
    logic       rr_busy,  fp_busy;

    if_axi_lite #(.ADDR_W(32), .DATA_W(32)) a0 ();
    if_axi_lite #(.ADDR_W(32), .DATA_W(32)) a1 ();
    if_axi_lite #(.ADDR_W(32), .DATA_W(32)) am ();
    if_axi_lite #(.ADDR_W(32), .DATA_W(32)) b0 ();
    if_axi_lite #(.ADDR_W(32), .DATA_W(32)) b1 ();
    if_axi_lite #(.ADDR_W(32), .DATA_W(32)) bm ();

    axil_read_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rstn(rstn), .s0(a0), .s1(a1), .m(am),
        .o_grant(rr_grant), .o_busy(rr_busy)
    );

    axil_read_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rstn(rstn), .s0(b0), .s1(b1), .m(bm),
        .o_grant(fp_grant), .o_busy(fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        a0.araddr = '0; a0.arprot = '0; a0.arvalid = 0; a0.rready = 0;
        a1.araddr = '0; a1.arprot = '0; a1.arvalid = 0; a1.rready = 0;
        b0.araddr = '0; b0.arprot = '0; b0.arvalid = 0; b0.rready = 0;
        b1.araddr = '0; b1.arprot = '0; b1.arvalid = 0; b1.rready = 0;
        a0.awaddr = '0; a0.awprot = '0; a0.awvalid = 0; a0.wdata = '0; a0.wstrb = '0; a0.wvalid = 0; a0.bready = 0;
        a1.awaddr = '0; a1.awprot = '0; a1.awvalid = 0; a1.wdata = '0; a1.wstrb = '0; a1.wvalid = 0; a1.bready = 0;
        b0.awaddr = '0; b0.awprot = '0; b0.awvalid = 0; b0.wdata = '0; b0.wstrb = '0; b0.wvalid = 0; b0.bready = 0;
        b1.awaddr = '0; b1.awprot = '0; b1.awvalid = 0; b1.wdata = '0; b1.wstrb = '0; b1.wvalid = 0; b1.bready = 0;
        am.arready = 0; am.rdata = '0; am.rresp = '0; am.rvalid = 0;
        am.awready = 0; am.wready = 0; am.bresp = '0; am.bvalid = 0;
        bm.arready = 0; bm.rdata = '0; bm.rresp = '0; bm.rvalid = 0;
        bm.awready = 0; bm.wready = 0; bm.bresp = '0; bm.bvalid = 0;

        // ---- Test 1: reset values, reset mid-transaction ----
        #2;
        chk("rst_grant",   rr_grant,   2'b00);
        chk("rst_busy",    rr_busy,    1'b0);
        chk("rst_marvalid", am.arvalid, 1'b0);
        chk("rst_maraddr", am.araddr,  32'h0);
        cyc(); cyc();
        rstn = 1'b1;
        cyc();
        a0.arvalid = 1; a0.araddr = 32'h40;
        #1;
        chk("t1_s0_arready", a0.arready, 1'b1);
        cyc();
        chk("t1_addr_arvalid", am.arvalid, 1'b1);
        chk("t1_addr_araddr",  am.araddr,  32'h40);
        chk("t1_addr_busy",    rr_busy,    1'b1);
        cyc();
        rstn = 1'b0;
        #1;
        chk("t1_mid_grant",   rr_grant,   2'b00);
        chk("t1_mid_busy",    rr_busy,    1'b0);
        chk("t1_mid_arvalid", am.arvalid, 1'b0);
        chk("t1_mid_araddr",  am.araddr,  32'h0);
        chk("t1_mid_arprot",  am.arprot,  3'b000);
        chk("t1_mid_arready", a0.arready, 1'b0);
        chk("t1_mid_rready",  am.rready,  1'b0);
        cyc();
        rstn = 1'b1;
        #1;
        chk("t1_rel_arready", a0.arready, 1'b1);
        cyc();
        chk("t1_rel_arvalid", am.arvalid, 1'b1);
        chk("t1_rel_araddr",  am.araddr,  32'h40);
        a0.arvalid = 0; am.arready = 1;
        cyc();
        am.arready = 0; am.rvalid = 1; am.rdata = 32'hCAFE_0001; a0.rready = 1;
        #1;
        chk("t1_rvalid", a0.rvalid, 1'b1);
        chk("t1_rdata",  a0.rdata,  32'hCAFE_0001);
        cyc();
        am.rvalid = 0; a0.rready = 0;
        #1;
        chk("t1_done_busy", rr_busy, 1'b0);

        // ---- Test 2: single port-0 read ----
        a0.arvalid = 1; a0.araddr = 32'h0000_0100; a0.arprot = 3'b010;
        #1;
        chk("t2_s0_arready", a0.arready, 1'b1);
        chk("t2_s1_arready", a1.arready, 1'b0);
        cyc();
        a0.arvalid = 0; am.arready = 1;
        #1;
        chk("t2_arvalid", am.arvalid, 1'b1);
        chk("t2_araddr",  am.araddr,  32'h100);
        chk("t2_arprot",  am.arprot,  3'b010);
        chk("t2_grant",   rr_grant,   2'b01);
        cyc();
        am.arready = 0; am.rvalid = 1; am.rdata = 32'hDEAD_BEEF; am.rresp = 2'b00; a0.rready = 1;
        #1;
        chk("t2_arvalid_drop", am.arvalid, 1'b0);
        chk("t2_s0_rvalid", a0.rvalid, 1'b1);
        chk("t2_s0_rdata",  a0.rdata,  32'hDEAD_BEEF);
        chk("t2_s0_rresp",  a0.rresp,  2'b00);
        chk("t2_s1_rvalid", a1.rvalid, 1'b0);
        chk("t2_m_rready",  am.rready, 1'b1);
        cyc();
        am.rvalid = 0; a0.rready = 0;
        #1;
        chk("t2_grant_clear", rr_grant, 2'b00);
        chk("t2_s0_rvalid_idle", a0.rvalid, 1'b0);

        // ---- Test 6: port-1 read with SLVERR ----
        a1.arvalid = 1; a1.araddr = 32'h200;
        #1;
        chk("t6_s1_arready", a1.arready, 1'b1);
        cyc();
        a1.arvalid = 0; am.arready = 1;
        cyc();
        am.arready = 0; am.rvalid = 1; am.rresp = 2'b10; am.rdata = 32'h0BAD_0BAD; a1.rready = 1;
        #1;
        chk("t6_grant",     rr_grant,  2'b10);
        chk("t6_s1_rvalid", a1.rvalid, 1'b1);
        chk("t6_s1_rresp",  a1.rresp,  2'b10);
        chk("t6_s0_rvalid", a0.rvalid, 1'b0);
        cyc();
        am.rvalid = 0; am.rresp = 2'b00; a1.rready = 0;
        #1;
        chk("t6_idle_busy",  rr_busy,  1'b0);
        chk("t6_idle_grant", rr_grant, 2'b00);

        // ---- Test 3: round-robin contention ----
        a0.arvalid = 1; a0.araddr = 32'h10; a0.rready = 1;
        a1.arvalid = 1; a1.araddr = 32'h20; a1.rready = 1;
        am.arready = 1; am.rvalid = 1; am.rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_s0_arready", a0.arready, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("t3_s1_arready", a1.arready, (i % 2 == 0) ? 1'b0 : 1'b1);
            cyc();
            chk("t3_araddr", am.araddr, (i % 2 == 0) ? 32'h10 : 32'h20);
            cyc();
            chk("t3_s0_rvalid", a0.rvalid, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("t3_s1_rvalid", a1.rvalid, (i % 2 == 0) ? 1'b0 : 1'b1);
            cyc();
        end
        a0.arvalid = 0; a1.arvalid = 0; a0.rready = 0; a1.rready = 0;
        am.arready = 0; am.rvalid = 0;

        // ---- Test 4: fixed-priority contention ----
        b0.arvalid = 1; b0.araddr = 32'h10; b0.rready = 1;
        b1.arvalid = 1; b1.araddr = 32'h20; b1.rready = 1;
        bm.arready = 1; bm.rvalid = 1; bm.rdata = 32'h8765_4321;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_s0_arready", b0.arready, 1'b1);
            chk("t4_s1_arready", b1.arready, 1'b0);
            cyc();
            chk("t4_araddr", bm.araddr, 32'h10);
            chk("t4_s1_arready_addr", b1.arready, 1'b0);
            cyc();
            chk("t4_s1_rvalid", b1.rvalid, 1'b0);
            cyc();
        end
        b0.arvalid = 0; b1.arvalid = 0; b0.rready = 0; b1.rready = 0;
        bm.arready = 0; bm.rvalid = 0;

        // ---- Test 5: backpressure on both channels ----
        a1.arvalid = 1; a1.araddr = 32'h300;
        #1;
        chk("t5_s1_arready", a1.arready, 1'b1);
        cyc();
        a1.arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_stall_arvalid", am.arvalid, 1'b1);
            chk("t5_stall_araddr",  am.araddr,  32'h300);
            cyc();
        end
        am.arready = 1;
        #1;
        chk("t5_hs_araddr", am.araddr, 32'h300);
        cyc();
        am.arready = 0; am.rvalid = 1; am.rdata = 32'h55AA_55AA;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_rready_hold", am.rready,  1'b0);
            chk("t5_s1_rvalid",   a1.rvalid,  1'b1);
            chk("t5_busy_hold",   rr_busy,    1'b1);
            cyc();
        end
        a1.rready = 1;
        #1;
        chk("t5_rready_hs", am.rready, 1'b1);
        chk("t5_rdata",     a1.rdata,  32'h55AA_55AA);
        chk("t5_busy_hs",   rr_busy,   1'b1);
        cyc();
        am.rvalid = 0; a1.rready = 0;
        #1;
        chk("t5_after_busy",  rr_busy,  1'b0);
        chk("t5_after_grant", rr_grant, 2'b00);

        // ---- Write-channel tie-offs ----
        chk("wr_m_awvalid", am.awvalid, 1'b0);
        chk("wr_m_wvalid",  am.wvalid,  1'b0);
        chk("wr_s0_bvalid", a0.bvalid,  1'b0);
        chk("wr_s1_awready", a1.awready, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
